uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS_DEF = 8;
  localparam int NUM_REQ       = 2;

  // One-hot requester mask from a requester index
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: bit-period counter; pulses o_tick on the last cycle of each serial bit.
// Latency: o_tick is combinational from the registered count; first tick CLKS_PER_BIT-1 cycles after restart.
// Backpressure: none; counts only while i_run is high.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_restart clears the count;
//        i_run enables counting; o_tick one-cycle pulse at terminal count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;

  assign o_tick = i_run && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_restart) begin
      cnt_q <= '0;
    end else if (i_run) begin
      // Wrap at the terminal count so the next bit starts from zero
      if (o_tick) cnt_q <= '0;
      else        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin shares one 8N1 UART TX line between two byte requesters.
// Latency: line drops to start bit the cycle after the o_ready handshake; frame lasts (DATA_BITS+2)*CLKS_PER_BIT cycles.
// Backpressure: o_ready only in IDLE, to the single selected requester; requesters hold i_valid until served.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/i_data per-requester byte offers;
//        o_ready accept strobe; o_grant one-hot frame owner; o_busy frame in flight; o_tx serial line.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
  output logic [NUM_REQ-1:0]             o_ready,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic                           o_tx
);

  localparam int IDX_W = $clog2(DATA_BITS);

  state_e                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   ptr_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   busy_q;
  logic                   tx_q;

  logic                   sel_vld;
  logic                   sel_idx;
  logic [DATA_BITS-1:0]   sel_byte;
  logic                   accept;
  logic                   bit_tick;

  // Single requester wins outright; on contention the pointer decides
  assign sel_vld  = |i_valid;
  assign sel_idx  = (i_valid == 2'b11) ? ptr_q : i_valid[1];
  assign sel_byte = sel_idx ? i_data[NUM_REQ*DATA_BITS-1 -: DATA_BITS] : i_data[DATA_BITS-1:0];
  assign accept   = (state_q == IDLE) && sel_vld;
  assign o_ready  = accept ? req_onehot(sel_idx) : '0;

  assign o_grant = grant_q;
  assign o_busy  = busy_q;
  assign o_tx    = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (accept),
    .i_run     (state_q != IDLE),
    .o_tick    (bit_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      ptr_q   <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= sel_byte;
            grant_q <= req_onehot(sel_idx);
            ptr_q   <= ~sel_idx;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q <= shift_q >> 1;
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              // Next bit is the one about to shift into position 0
              tx_q  <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            busy_q  <= 1'b0;
            grant_q <= '0;
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      vld  [2];
  logic [1:0][7:0] dat  [2];
  logic [1:0]      rdy  [2];
  logic [1:0]      gnt  [2];
  logic            busy [2];
  logic            tx   [2];

  // Bit period of each instance: index 0 runs at 4 clocks/bit, index 1 at 2
  int cpb [2] = '{4, 2};

  // Reference model: per instance, frame start cycle, byte and owner
  bit         act [2];
  int         st  [2];
  logic [7:0] fb  [2];
  logic [1:0] fg  [2];
  bit         ptr [2];
  logic [1:0] clr [2];
  bit         hold;
  int         cyc;
  int         n_chk;
  int         n_pass;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .i_data(dat[0]),
    .o_ready(rdy[0]), .o_grant(gnt[0]), .o_busy(busy[0]), .o_tx(tx[0])
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(2), .DATA_BITS(8)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .i_data(dat[1]),
    .o_ready(rdy[1]), .o_grant(gnt[1]), .o_busy(busy[1]), .o_tx(tx[1])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Called at posedge+1 with inputs for this cycle already applied.
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic       ex_tx;
      logic [1:0] ex_rdy;
      int         bn;
      bit         w;
      if (act[d] && (cyc - st[d]) >= (NB + 2) * cpb[d]) act[d] = 0;
      ex_tx = 1'b1;
      if (act[d]) begin
        bn = (cyc - st[d]) / cpb[d];
        if (bn == 0)       ex_tx = 1'b0;
        else if (bn <= NB) ex_tx = fb[d][bn-1];
      end
      chk($sformatf("tx%0d", d),   16'(tx[d]),   16'(ex_tx));
      chk($sformatf("busy%0d", d), 16'(busy[d]), 16'(act[d]));
      chk($sformatf("gnt%0d", d),  16'(gnt[d]),  act[d] ? 16'(fg[d]) : 16'h0);
      ex_rdy = 2'b00;
      w      = 1'b0;
      if (!act[d] && vld[d] != 2'b00) begin
        w      = (vld[d] == 2'b11) ? ptr[d] : vld[d][1];
        ex_rdy = w ? 2'b10 : 2'b01;
      end
      chk($sformatf("rdy%0d", d), 16'(rdy[d]), 16'(ex_rdy));
      clr[d] = 2'b00;
      if (ex_rdy != 2'b00) begin
        act[d] = 1;
        st[d]  = cyc + 1;
        fb[d]  = dat[d][w];
        fg[d]  = ex_rdy;
        ptr[d] = !w;
        if (!hold) clr[d] = ex_rdy;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    // Served requester drops valid and scribbles its data lines
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++)
        if (clr[d][k]) begin
          vld[d][k] = 1'b0;
          dat[d][k] = 8'($urandom);
        end
  endtask

  task automatic rand_drive();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++)
        if (!vld[d][k]) begin
          dat[d][k] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) vld[d][k] = 1'b1;
        end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0;
      ptr[d] = 0;
      clr[d] = 2'b00;
      vld[d] = 2'b00;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    hold   = 0;
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      dat[d] = '0;
      st[d]  = 0;
      fb[d]  = '0;
      fg[d]  = '0;
    end
    model_reset();

    // Reset state
    #23;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_tx%0d", d),   16'(tx[d]),   16'h1);
      chk($sformatf("rst_busy%0d", d), 16'(busy[d]), 16'h0);
      chk($sformatf("rst_gnt%0d", d),  16'(gnt[d]),  16'h0);
      chk($sformatf("rst_rdy%0d", d),  16'(rdy[d]),  16'h0);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) cycle();

    // Single byte 0x55 from requester 0
    for (int d = 0; d < 2; d++) begin
      vld[d]    = 2'b01;
      dat[d][0] = 8'h55;
    end
    repeat (45) cycle();

    // Both requesters held valid: alternate A5 / 3C
    hold = 1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 2'b11;
      dat[d] = {8'h3C, 8'hA5};
    end
    repeat (123) cycle();
    hold = 0;
    for (int d = 0; d < 2; d++) vld[d] = 2'b00;
    repeat (45) cycle();

    // Requester 1 arrives mid-frame; must wait for IDLE
    for (int d = 0; d < 2; d++) begin
      vld[d]    = 2'b01;
      dat[d][0] = 8'hFF;
    end
    repeat (10) cycle();
    for (int d = 0; d < 2; d++) begin
      vld[d][1] = 1'b1;
      dat[d][1] = 8'h00;
    end
    repeat (90) cycle();

    // Fairness: requester 1 alone for several frames, then contention
    hold = 1;
    for (int d = 0; d < 2; d++) begin
      vld[d]    = 2'b10;
      dat[d][1] = 8'($urandom);
    end
    repeat (92) cycle();
    hold = 0;
    for (int d = 0; d < 2; d++) begin
      vld[d][0] = 1'b1;
      dat[d][0] = 8'($urandom);
    end
    repeat (100) cycle();
    for (int d = 0; d < 2; d++) vld[d] = 2'b00;
    repeat (50) cycle();

    // Reset during data bit 3 of the 4-clocks/bit instance
    for (int d = 0; d < 2; d++) begin
      vld[d]    = 2'b01;
      dat[d][0] = 8'($urandom);
    end
    repeat (18) cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_rst_tx%0d", d),   16'(tx[d]),   16'h1);
      chk($sformatf("mid_rst_busy%0d", d), 16'(busy[d]), 16'h0);
      chk($sformatf("mid_rst_gnt%0d", d),  16'(gnt[d]),  16'h0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc += 3;
    repeat (20) cycle();
    // Pointer must be back at requester 0 after reset
    for (int d = 0; d < 2; d++) begin
      vld[d] = 2'b11;
      dat[d] = {8'($urandom), 8'($urandom)};
    end
    repeat (90) cycle();

    // Randomized traffic
    repeat (1500) begin
      rand_drive();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
